transmitter: RTL and testbench



---
 rtl/transmitter_pkg.sv | 24 ++
 rtl/uart_tx_byte.sv | 77 +++++++
 rtl/transmitter.sv | 97 +++++++++
 tb/tb_transmitter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/transmitter_pkg.sv
// Shared encodings and frame constants for the sample-word UART transmitter.
package transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMPTY = 2'd1,
    FRAME = 2'd2
  } state_e;

  localparam int   UART_FRAME_BITS = 10;
  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;
  localparam int   GROUPS          = 4;
  localparam int   GROUP_BITS      = 8;

  // Lowest-index set bit wins; an all-zero mask yields group 0 (never used).
  function automatic logic [1:0] lowest_group(input logic [GROUPS-1:0] mask);
    lowest_group = 2'd0;
    for (int g = GROUPS - 1; g >= 0; g--) begin
      if (mask[g]) lowest_group = 2'(g);
    end
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1 byte serializer; a load in the stop bit's final cycle chains the next frame gaplessly.
module uart_tx_byte
  import transmitter_pkg::*;
#(
  parameter int BITLENGTH = 108
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       last_cycle
);

  localparam int              BAUD_W   = $clog2(BITLENGTH);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(BITLENGTH - 1);
  localparam logic [3:0]      LAST_BIT = 4'(UART_FRAME_BITS - 1);

  logic              active_q, active_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  assign last_cycle = active_q && (bit_q == LAST_BIT) && (baud_q == BAUD_MAX);
  assign tx         = tx_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (load) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = data;
      tx_d     = START_BIT;
    end else if (active_q) begin
      if (baud_q == BAUD_MAX) begin
        baud_d = '0;
        if (bit_q == LAST_BIT) begin
          active_d = 1'b0;
          bit_d    = '0;
          tx_d     = STOP_BIT;
        end else begin
          // Ones shift in behind the data, so after d7 the LSB is the stop bit.
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_q[0];
          shift_d = {STOP_BIT, shift_q[7:1]};
        end
      end else begin
        baud_d = baud_q + BAUD_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= STOP_BIT;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/transmitter.sv
// Latches a sample word and group mask, then sends each enabled group as a UART byte, group 0 first.
module transmitter
  import transmitter_pkg::*;
#(
  parameter int BITLENGTH = 108,
  parameter int WIDTH     = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             send,
  input  logic [WIDTH-1:0] wrdata,
  input  logic [3:0]       disabledGroups,
  output logic             busy,
  output logic             tx
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [GROUPS-1:0]  mask_q, mask_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic               last_cycle;
  logic               load;
  logic [GROUPS-1:0]  remaining;
  logic [GROUPS-1:0]  load_mask;
  logic [1:0]         load_group;
  logic [7:0]         load_data;

  assign accept     = send && (state_q == IDLE) && !busy_q;
  assign remaining  = mask_q & (mask_q - 4'd1);
  assign load_mask  = start_q ? mask_q : remaining;
  assign load       = start_q || (last_cycle && (remaining != '0));
  assign load_group = lowest_group(load_mask);
  assign load_data  = word_q[{load_group, 3'b000} +: GROUP_BITS];
  assign busy       = busy_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d = wrdata;
          mask_d = ~disabledGroups;
          if (mask_d != '0) begin
            state_d = FRAME;
            start_d = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      EMPTY:   state_d = IDLE;
      FRAME: begin
        if (last_cycle) begin
          mask_d = remaining;
          if (remaining == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // busy lags acceptance by a cycle but must drop on the edge that ends the last stop bit.
    busy_d = (state_q == EMPTY) || ((state_q == FRAME) && (state_d == FRAME));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      mask_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  uart_tx_byte #(
    .BITLENGTH(BITLENGTH)
  ) u_uart (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .data      (load_data),
    .tx        (tx),
    .last_cycle(last_cycle)
  );

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter with BITLENGTH=4: frame timing, masking, ignored sends and reset abort.
module tb_transmitter;

  localparam int BL = 4;
  localparam int FRAME_CYCLES = 10 * BL;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        send = 1'b0;
  logic [31:0] wrdata = '0;
  logic [3:0]  disabledGroups = '0;
  logic        busy;
  logic        tx;

  int checks = 0;
  int errors = 0;
  logic [9:0] first_frame;

  transmitter #(.BITLENGTH(BL), .WIDTH(32)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .send          (send),
    .wrdata        (wrdata),
    .disabledGroups(disabledGroups),
    .busy          (busy),
    .tx            (tx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench just after the edge that samples send (edge 0).
  task automatic send_word(input string tag, input logic [31:0] w, input logic [3:0] dg);
    wrdata = w;
    disabledGroups = dg;
    send = 1'b1;
    tick();
    send = 1'b0;
    check({tag, "_lag_busy"}, busy, 1'b0);
    check({tag, "_lag_tx"}, tx, 1'b1);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s_idle_tx%0d", tag, i), tx, 1'b1);
      check($sformatf("%s_idle_busy%0d", tag, i), busy, 1'b0);
    end
  endtask

  // Checks tx/busy every cycle of n_frames back-to-back frames, then the idle edge after.
  // exp_bytes holds the bytes in transmit order, first byte in bits [7:0].
  task automatic run_stream(input string tag, input logic [31:0] exp_bytes, input int n_frames,
                            input int inj_cycle, input logic inj_send, input logic [31:0] inj_word,
                            input logic [3:0] inj_dg, output logic [9:0] frame0);
    logic [7:0] byte_v;
    logic       exp_tx;
    int         f, b;
    frame0 = '0;
    for (int k = 0; k < n_frames * FRAME_CYCLES; k++) begin
      tick();
      send = 1'b0;
      f = k / FRAME_CYCLES;
      b = (k % FRAME_CYCLES) / BL;
      byte_v = exp_bytes[8*f +: 8];
      if (b == 0)      exp_tx = 1'b0;
      else if (b == 9) exp_tx = 1'b1;
      else             exp_tx = byte_v[b-1];
      check($sformatf("%s_tx_c%0d", tag, k), tx, exp_tx);
      check($sformatf("%s_busy_c%0d", tag, k), busy, 1'b1);
      if (f == 0 && (k % BL) == 0) frame0[b] = tx;
      if (k == inj_cycle) begin
        send = inj_send;
        wrdata = inj_word;
        disabledGroups = inj_dg;
      end
    end
    tick();
    send = 1'b0;
    check({tag, "_end_busy"}, busy, 1'b0);
    check({tag, "_end_tx"}, tx, 1'b1);
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    reset_n = 1'b1;
    idle_cycles("post_reset", 2);

    // All four groups, bytes 78 56 34 12
    send_word("all4", 32'h1234_5678, 4'b0000);
    run_stream("all4", 32'h1234_5678, 4, -1, 1'b0, '0, 4'b0000, first_frame);

    // Sent one cycle after busy fell: groups 0 and 2 only
    send_word("mask1010", 32'hA5C3_0F81, 4'b1010);
    run_stream("mask1010", 32'h0000_C381, 2, -1, 1'b0, '0, 4'b1010, first_frame);
    check("bits_0x81", {22'd0, first_frame}, {22'd0, 10'b11_0000_0010});
    idle_cycles("mask1010", 2);

    // Every group disabled: one busy cycle, tx quiet
    send_word("empty", 32'hFFFF_FFFF, 4'b1111);
    tick();
    check("empty_busy1", busy, 1'b1);
    check("empty_tx1", tx, 1'b1);
    tick();
    check("empty_busy2", busy, 1'b0);
    check("empty_tx2", tx, 1'b1);
    idle_cycles("empty", 2);

    // Second send mid-frame is ignored
    send_word("midsend", 32'h1234_5678, 4'b0000);
    run_stream("midsend", 32'h1234_5678, 4, 50, 1'b1, 32'hDEAD_BEEF, 4'b0000, first_frame);
    idle_cycles("midsend", 2);

    // Send sampled on the edge busy falls is ignored
    send_word("fallsend", 32'h1234_5678, 4'b0000);
    run_stream("fallsend", 32'h1234_5678, 4, 4 * FRAME_CYCLES - 1, 1'b1, 32'h0000_00AA, 4'b1110,
               first_frame);
    idle_cycles("fallsend", 3);

    // disabledGroups change after acceptance has no effect
    send_word("dgchange", 32'h1234_5678, 4'b0000);
    run_stream("dgchange", 32'h1234_5678, 4, 5, 1'b0, 32'h1234_5678, 4'b1111, first_frame);
    idle_cycles("dgchange", 2);

    // Reset during d3 of the first byte abandons the frame
    send_word("abort", 32'h1234_5678, 4'b0000);
    for (int k = 0; k < 18; k++) tick();
    check("abort_busy_pre", busy, 1'b1);
    reset_n = 1'b0;
    tick();
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    reset_n = 1'b1;
    idle_cycles("abort", 3);
    send_word("after_abort", 32'h0000_00FF, 4'b1110);
    run_stream("after_abort", 32'h0000_00FF, 1, -1, 1'b0, '0, 4'b1110, first_frame);
    idle_cycles("after_abort", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
